// File: rtl/fpdiv_rnd_pack_if.sv
// Handshake/data bundle between the divide front end, the divider primitive
// and the normalize/round/pack back end.
interface fpdiv_rnd_pack_if;
    logic         in_valid;
    logic [111:0] q;
    logic [55:0]  r;
    logic         sgn;
    logic [12:0]  exp;
    logic [2:0]   rm;
    logic         spec;
    logic [63:0]  spec_val;
    logic [1:0]   spec_flags;
    logic [63:0]  o;
    logic         o_valid;
    logic [4:0]   flags;
    logic         busy;

    modport master (
        output in_valid, q, r, sgn, exp, rm, spec, spec_val, spec_flags,
        input  o, o_valid, flags, busy
    );

    modport slave (
        input  in_valid, q, r, sgn, exp, rm, spec, spec_val, spec_flags,
        output o, o_valid, flags, busy
    );
endinterface

// File: rtl/fpdiv_rnd_pack.sv
// Post-divide normalize / subnormal-denormalize / round / pack for binary64.
// Stage p0 captures the divider outputs, p1 holds the normalized significand,
// p2 holds the denormalized significand, and the output register holds the
// packed result. One result per cycle, no backpressure.
module fpdiv_rnd_pack (
    input  logic            clk,
    input  logic            rst,
    fpdiv_rnd_pack_if.slave bus
);
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Round-increment decision; unused codes fall back to nearest-even.
    function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                       input logic lsb, input logic g, input logic s);
        case (rm)
            RM_RNE:  round_inc = g & (s | lsb);
            RM_RTZ:  round_inc = 1'b0;
            RM_RDN:  round_inc = sgn & (g | s);
            RM_RUP:  round_inc = ~sgn & (g | s);
            RM_RMM:  round_inc = g;
            default: round_inc = g & (s | lsb);
        endcase
    endfunction

    // Overflow saturation: infinity unless the mode rounds toward zero for this sign.
    function automatic logic [63:0] ovf_result(input logic [2:0] rm, input logic sgn);
        logic to_inf;
        case (rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sgn;
            RM_RUP:  to_inf = ~sgn;
            default: to_inf = 1'b1;
        endcase
        ovf_result = to_inf ? {sgn, 11'h7FF, 52'd0} : {sgn, 11'h7FE, {52{1'b1}}};
    endfunction

    logic                r_vld_p0, r_vld_p1, r_vld_p2;
    logic [56:0]         r_q_p0;
    logic [55:0]         r_r_p0;
    logic signed [12:0]  r_exp_p0;
    logic [52:0]         r_m_p1, r_m_p2;
    logic                r_g_p1, r_g_p2, r_s_p1, r_s_p2;
    logic signed [14:0]  r_e_p1;
    logic [11:0]         r_e_p2;
    logic                r_tiny_p2;
    logic                r_sgn_p0, r_sgn_p1, r_sgn_p2;
    logic [2:0]          r_rm_p0, r_rm_p1, r_rm_p2;
    logic                r_spec_p0, r_spec_p1, r_spec_p2;
    logic [63:0]         r_sval_p0, r_sval_p1, r_sval_p2;
    logic [1:0]          r_sflg_p0, r_sflg_p1, r_sflg_p2;
    logic [63:0]         r_o;
    logic [4:0]          r_flg;
    logic                r_ovld;

    // ---- p0 -> p1 : normalize on the quotient's leading bit
    logic [52:0]         w_m_n;
    logic                w_g_n, w_s_n;
    logic signed [14:0]  w_e_n;

    // Pick the 53-bit significand window, guard and sticky from the quotient.
    always_comb begin
        w_e_n = 15'(r_exp_p0);
        if (r_q_p0[56]) begin
            w_m_n = r_q_p0[56:4];
            w_g_n = r_q_p0[3];
            w_s_n = (|r_q_p0[2:0]) | (|r_r_p0);
        end else begin
            w_m_n = r_q_p0[55:3];
            w_g_n = r_q_p0[2];
            w_s_n = (|r_q_p0[1:0]) | (|r_r_p0);
            w_e_n = w_e_n - 15'sd1;
        end
    end

    // ---- p1 -> p2 : denormalize tiny results (tininess before rounding)
    logic signed [14:0]  w_dist;
    logic [5:0]          w_sh;
    logic [108:0]        w_wide;
    logic                w_tiny;
    logic [52:0]         w_m_s;
    logic                w_g_s, w_s_s;
    logic [11:0]         w_e_s;

    // Shift {m,g} right; the last bit leaving m becomes g, the rest fold into s.
    always_comb begin
        w_dist = 15'sd1 - r_e_p1;
        w_tiny = (r_e_p1 <= 15'sd0);
        w_sh   = 6'd0;
        if (w_tiny) w_sh = (w_dist > 15'sd55) ? 6'd55 : w_dist[5:0];
        w_wide = {r_m_p1, r_g_p1, 55'd0} >> w_sh;
        w_m_s  = w_wide[108:56];
        w_g_s  = w_wide[55];
        w_s_s  = r_s_p1 | (|w_wide[54:0]);
        w_e_s  = w_tiny ? 12'd0 : r_e_p1[11:0];
    end

    // ---- p2 -> out : round, detect overflow, pack
    logic                w_inc, w_of, w_nx, w_uf;
    logic [53:0]         w_mr;
    logic [12:0]         w_e_r;
    logic [63:0]         w_res;
    logic [4:0]          w_flg;

    // Round the significand, carry into the exponent, then select packed result.
    always_comb begin
        w_inc = round_inc(r_rm_p2, r_sgn_p2, r_m_p2[0], r_g_p2, r_s_p2);
        w_mr  = {1'b0, r_m_p2} + 54'(w_inc);
        w_e_r = {1'b0, r_e_p2};
        if (w_mr[53]) w_e_r = w_e_r + 13'd1;
        else if ((r_e_p2 == 12'd0) && w_mr[52]) w_e_r = 13'd1;
        w_of  = (w_e_r >= 13'd2047);
        w_nx  = r_g_p2 | r_s_p2 | w_of;
        w_uf  = r_tiny_p2 & w_nx;
        if (r_spec_p2) begin
            w_res = r_sval_p2;
            w_flg = {r_sflg_p2, 3'b000};
        end else if (w_of) begin
            w_res = ovf_result(r_rm_p2, r_sgn_p2);
            w_flg = {2'b00, 1'b1, w_uf, 1'b1};
        end else begin
            w_res = {r_sgn_p2, w_e_r[10:0], w_mr[51:0]};
            w_flg = {2'b00, 1'b0, w_uf, w_nx};
        end
    end

    // Valid chain and output registers; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_ovld   <= 1'b0;
            r_o      <= 64'd0;
            r_flg    <= 5'd0;
        end else begin
            r_vld_p0 <= bus.in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            r_ovld   <= r_vld_p2;
            if (r_vld_p2) begin
                r_o   <= w_res;
                r_flg <= w_flg;
            end
        end
    end

    // Capture divider outputs and front-end operands on the done pulse.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_q_p0    <= bus.q[56:0];
            r_r_p0    <= bus.r;
            r_exp_p0  <= bus.exp;
            r_sgn_p0  <= bus.sgn;
            r_rm_p0   <= bus.rm;
            r_spec_p0 <= bus.spec;
            r_sval_p0 <= bus.spec_val;
            r_sflg_p0 <= bus.spec_flags;
        end
    end

    // Advance the normalized operand into p1.
    always_ff @(posedge clk) begin
        if (r_vld_p0) begin
            r_m_p1    <= w_m_n;
            r_g_p1    <= w_g_n;
            r_s_p1    <= w_s_n;
            r_e_p1    <= w_e_n;
            r_sgn_p1  <= r_sgn_p0;
            r_rm_p1   <= r_rm_p0;
            r_spec_p1 <= r_spec_p0;
            r_sval_p1 <= r_sval_p0;
            r_sflg_p1 <= r_sflg_p0;
        end
    end

    // Advance the denormalized operand into p2.
    always_ff @(posedge clk) begin
        if (r_vld_p1) begin
            r_m_p2    <= w_m_s;
            r_g_p2    <= w_g_s;
            r_s_p2    <= w_s_s;
            r_e_p2    <= w_e_s;
            r_tiny_p2 <= w_tiny;
            r_sgn_p2  <= r_sgn_p1;
            r_rm_p2   <= r_rm_p1;
            r_spec_p2 <= r_spec_p1;
            r_sval_p2 <= r_sval_p1;
            r_sflg_p2 <= r_sflg_p1;
        end
    end

    assign bus.o       = r_o;
    assign bus.flags   = r_flg;
    assign bus.o_valid = r_ovld;
    assign bus.busy    = r_vld_p0 | r_vld_p1 | r_vld_p2;
endmodule

// File: tb/tb_fpdiv_rnd_pack.sv
// Bench for fpdiv_rnd_pack: directed vector table, throughput and reset
// sequences, then random traffic checked against an arithmetic model.
module tb_fpdiv_rnd_pack;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpdiv_rnd_pack_if bus();
    fpdiv_rnd_pack dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [111:0] q;
        logic [55:0]  r;
        logic         sgn;
        logic [12:0]  exp;
        logic [2:0]   rm;
        logic         spec;
        logic [63:0]  spec_val;
        logic [1:0]   spec_flags;
        logic [63:0]  eo;
        logic [4:0]   ef;
    } vec_t;

    typedef struct {
        logic [63:0] o;
        logic [4:0]  f;
        logic [63:0] t;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endfunction

    function automatic vec_t mk(input logic [111:0] q, input logic [55:0] r, input logic sgn,
                                input logic [12:0] exp, input logic [2:0] rm, input logic spec,
                                input logic [63:0] sv, input logic [1:0] sf,
                                input logic [63:0] eo, input logic [4:0] ef);
        vec_t v;
        v.q = q; v.r = r; v.sgn = sgn; v.exp = exp; v.rm = rm; v.spec = spec;
        v.spec_val = sv; v.spec_flags = sf; v.eo = eo; v.ef = ef;
        return v;
    endfunction

    // Reference: one combined shift of the exact quotient, then rounding by
    // integer addition on the magnitude so carries flow into the exponent field.
    function automatic vec_t model(input vec_t v);
        logic [127:0] full, m, low, mag;
        int e, sh, tot;
        logic g, s, inc, tiny, of, nx, to_inf;
        vec_t w = v;
        if (v.spec) begin
            w.eo = v.spec_val;
            w.ef = {v.spec_flags, 3'b000};
            return w;
        end
        full = {71'd0, v.q[56:0]};
        e = int'($signed(v.exp));
        if (v.q[56]) tot = 4;
        else begin tot = 3; e = e - 1; end
        tiny = (e <= 0);
        sh = 0;
        if (tiny) begin
            sh = (1 - e > 55) ? 55 : 1 - e;
            e = 0;
        end
        tot = tot + sh;
        m   = full >> tot;
        g   = full[tot-1];
        low = full & ((128'd1 << (tot - 1)) - 128'd1);
        s   = (low != 128'd0) || (v.r != 56'd0);
        case (v.rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = v.sgn & (g | s);
            3'd3:    inc = ~v.sgn & (g | s);
            3'd4:    inc = g;
            default: inc = g & (s | m[0]);
        endcase
        m = m + 128'(inc);
        if (e == 0) mag = m;
        else mag = (128'(e - 1) << 52) + m;
        of = (mag >= 128'h7FF0000000000000);
        nx = g | s | of;
        case (v.rm)
            3'd1:    to_inf = 1'b0;
            3'd2:    to_inf = v.sgn;
            3'd3:    to_inf = ~v.sgn;
            default: to_inf = 1'b1;
        endcase
        if (of) w.eo = to_inf ? {v.sgn, 63'h7FF0000000000000} : {v.sgn, 63'h7FEFFFFFFFFFFFFF};
        else    w.eo = {v.sgn, mag[62:0]};
        w.ef = {2'b00, of, tiny & nx, nx};
        return w;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int e;
        v.q = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        if ($urandom_range(0, 1) == 1) v.q[56] = 1'b1;
        else begin v.q[56] = 1'b0; v.q[55] = 1'b1; end
        if ($urandom_range(0, 3) == 0) v.q[3:0] = 4'd0;
        v.r = ($urandom_range(0, 2) == 0) ? 56'd0 : 56'({$urandom(), $urandom()});
        case ($urandom_range(0, 3))
            0:       e = int'($urandom_range(0, 120)) - 60;
            1:       e = int'($urandom_range(1, 2046));
            2:       e = int'($urandom_range(2030, 2060));
            default: e = int'($urandom_range(0, 8191)) - 4096;
        endcase
        v.exp = 13'(e);
        v.sgn = 1'($urandom());
        v.rm = 3'($urandom_range(0, 7));
        v.spec = ($urandom_range(0, 15) == 0);
        v.spec_val = 64'({$urandom(), $urandom()});
        v.spec_flags = 2'($urandom());
        return model(v);
    endfunction

    // Present one operand for a single edge; expect it on the output 3 edges later.
    task automatic send(input vec_t v);
        exp_t x;
        bus.q = v.q; bus.r = v.r; bus.sgn = v.sgn; bus.exp = v.exp; bus.rm = v.rm;
        bus.spec = v.spec; bus.spec_val = v.spec_val; bus.spec_flags = v.spec_flags;
        bus.in_valid = 1'b1;
        @(posedge clk);
        x.o = v.eo; x.f = v.ef; x.t = 64'($time) + 64'd30;
        sb.push_back(x);
        #1;
        bus.in_valid = 1'b0;
        bus.q = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        bus.r = 56'({$urandom(), $urandom()});
        bus.exp = 13'($urandom()); bus.sgn = 1'($urandom()); bus.rm = 3'($urandom());
        bus.spec = 1'($urandom()); bus.spec_val = 64'({$urandom(), $urandom()});
        bus.spec_flags = 2'($urandom());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor on the falling edge: timing, order, data and hold behaviour.
    logic [63:0] hold_o = 64'd0;
    initial begin
        exp_t x;
        logic [63:0] tm;
        forever begin
            @(negedge clk);
            tm = 64'($time) - 64'd5;
            if (rst) hold_o = 64'd0;
            else if (sb.size() > 0 && sb[0].t == tm) begin
                x = sb.pop_front();
                chk("o_valid_due", 64'(bus.o_valid), 64'd1);
                chk("o", bus.o, x.o);
                chk("flags", 64'(bus.flags), 64'(x.f));
                hold_o = bus.o;
            end else begin
                if (bus.o_valid !== 1'b0) chk("o_valid_spurious", 64'(bus.o_valid), 64'd0);
                chk("o_hold", bus.o, hold_o);
            end
        end
    end

    vec_t tbl[16];
    vec_t tp[4];

    initial begin
        bus.in_valid = 1'b0; bus.q = '0; bus.r = '0; bus.sgn = 1'b0; bus.exp = '0;
        bus.rm = '0; bus.spec = 1'b0; bus.spec_val = '0; bus.spec_flags = '0;
        #1 rst = 1'b1;
        idle(3);
        chk("rst_o", bus.o, 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        tbl[0]  = mk(112'h100000000000000, 56'd0, 1'b0, 13'd1023, 3'd0, 1'b0, 64'd0, 2'd0, 64'h3FF0000000000000, 5'b00000);
        tbl[1]  = mk(112'hAAAAAAAAAAAAAA, 56'd2, 1'b0, 13'd1023, 3'd0, 1'b0, 64'd0, 2'd0, 64'h3FE5555555555555, 5'b00001);
        tbl[2]  = mk(112'hAAAAAAAAAAAAAA, 56'd2, 1'b0, 13'd1023, 3'd3, 1'b0, 64'd0, 2'd0, 64'h3FE5555555555556, 5'b00001);
        tbl[3]  = mk(112'h100000000000000, 56'd0, 1'b0, 13'd2047, 3'd0, 1'b0, 64'd0, 2'd0, 64'h7FF0000000000000, 5'b00101);
        tbl[4]  = mk(112'h100000000000000, 56'd0, 1'b0, 13'd2047, 3'd1, 1'b0, 64'd0, 2'd0, 64'h7FEFFFFFFFFFFFFF, 5'b00101);
        tbl[5]  = mk(112'h100000000000000, 56'd0, 1'b0, 13'd0, 3'd0, 1'b0, 64'd0, 2'd0, 64'h0008000000000000, 5'b00000);
        tbl[6]  = mk(112'h100000000000000, 56'd1, 1'b0, 13'd0, 3'd3, 1'b0, 64'd0, 2'd0, 64'h0008000000000001, 5'b00011);
        tbl[7]  = mk(112'h100000000000000, 56'd0, 1'b1, 13'd1023, 3'd2, 1'b0, 64'd0, 2'd0, 64'hBFF0000000000000, 5'b00000);
        tbl[8]  = mk(112'h100000000000000, 56'd0, 1'b1, 13'd2047, 3'd2, 1'b0, 64'd0, 2'd0, 64'hFFF0000000000000, 5'b00101);
        tbl[9]  = mk(112'h100000000000000, 56'd0, 1'b1, 13'd2047, 3'd3, 1'b0, 64'd0, 2'd0, 64'hFFEFFFFFFFFFFFFF, 5'b00101);
        tbl[10] = mk(112'hAAAAAAAAAAAAAA, 56'd2, 1'b0, 13'd1023, 3'd7, 1'b0, 64'd0, 2'd0, 64'h3FE5555555555555, 5'b00001);
        tbl[11] = mk(112'h1FFFFFFFFFFFFFF, 56'd0, 1'b0, 13'd1023, 3'd0, 1'b0, 64'd0, 2'd0, 64'h4000000000000000, 5'b00001);
        tbl[12] = mk(112'h1FFFFFFFFFFFFFF, 56'd0, 1'b0, 13'd0, 3'd0, 1'b0, 64'd0, 2'd0, 64'h0010000000000000, 5'b00011);
        tbl[13] = mk(112'h100000000000000, 56'd0, 1'b0, 13'h1F38, 3'd3, 1'b0, 64'd0, 2'd0, 64'h0000000000000001, 5'b00011);
        tbl[14] = mk(112'h100000000000000, 56'd0, 1'b0, 13'd1023, 3'd0, 1'b1, 64'h7FF8000000000000, 2'b10, 64'h7FF8000000000000, 5'b10000);
        tbl[15] = mk({55'h7FFFFFFFFFFFFF, 57'h100000000000000}, 56'd0, 1'b0, 13'd1023, 3'd0, 1'b0, 64'd0, 2'd0, 64'h3FF0000000000000, 5'b00000);

        for (int i = 0; i < 16; i++) begin
            send(tbl[i]);
            chk("busy_inflight", 64'(bus.busy), 64'd1);
            idle(4);
            chk("busy_idle", 64'(bus.busy), 64'd0);
        end

        // Back-to-back issue including a bypass operand.
        tp[0] = model(tbl[0]);
        tp[1] = model(tbl[1]);
        tp[2] = model(tbl[14]);
        tp[3] = model(tbl[3]);
        for (int i = 0; i < 4; i++) send(tp[i]);
        idle(5);

        // Reset while two operands are in flight.
        send(tbl[2]);
        send(tbl[11]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_o", bus.o, 64'd0);
        chk("midrst_flags", 64'(bus.flags), 64'd0);
        chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        chk("postrst_busy", 64'(bus.busy), 64'd0);
        chk("postrst_o", bus.o, 64'd0);
        send(tbl[0]);
        idle(4);

        // Random traffic with random gaps.
        for (int i = 0; i < 400; i++) begin
            int gap;
            send(rand_vec());
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fpdiv_rnd_pack.md
# fpdiv_rnd_pack

Post-divide normalize/round/pack pipeline for binary64 division. Consumes the raw 112-bit quotient, remainder and completion pulse of the radix-16 divider primitive (WID1 = 56), plus the sign, exponent and special-case data prepared by the divide front end. Produces a packed IEEE-754 binary64 result and exception flags. Three-stage pipeline, one result per cycle, no backpressure.

## Interface
- RM_RNE..RM_RMM: fixed encodings 0..4 (RNE, RTZ, RDN toward -inf, RUP toward +inf, RMM nearest-ties-away); codes 5-7 behave as RNE.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  one-cycle pulse; driven by the divider `done`.
- q  in  112  divider quotient, floor(a·2^56/b), with 53-bit significands in a[52:0] and b[52:0].
- r  in  56  divider remainder.
- sgn  in  1  result sign (sa^sb).
- exp  in  13  signed, biased quotient exponent ea−eb+1023.
- rm  in  3  rounding mode.
- spec  in  1  special-case bypass (NaN/inf/zero results decided upstream).
- spec_val  in  64  bypass result.
- spec_flags  in  2  {NV,DZ} for the bypass.
- o  out  64  packed result; reset 0; holds until the next result.
- o_valid  out  1  one-cycle pulse; reset 0.
- flags  out  5  {NV,DZ,OF,UF,NX}; reset 0; updated with o.
- busy  out  1  any stage valid; reset 0.

## Operation
- Sample in_valid, q, r, sgn, exp, rm, spec, spec_val and spec_flags only when in_valid=1. Each stage has its own valid bit, and all operands travel with their stage.
- S1, normalize:
  - If q[56]=1: m=q[56:4], g=q[3], s=|q[2:0] | (r≠0), e=exp.
  - Else: m=q[55:3], g=q[2], s=|q[1:0] | (r≠0), e=exp−1.
  - Upper bits q[111:57] are ignored.
- S2, subnormal:
  - If e≤0: tiny=1, sh=min(1−e,55). Shift {m,g} right by sh. g takes the last bit shifted below m. Every other lost bit ORs into s. Set e=0.
  - Else tiny=0.
  - Tininess is detected before rounding.
- S3, round and pack:
  - inc decision by mode:
    - RNE: g&(s|m[0]).
    - RTZ: 0.
    - RDN: sgn&(g|s).
    - RUP: ~sgn&(g|s).
    - RMM: g.
  - mr=m+inc, 54 bits wide.
  - If mr[53]=1: e=e+1 and fraction=0.
  - If e=0 and mr[52]=1 (subnormal rounded up to normal): e=1.
  - Result = {sgn, e[10:0], mr[51:0]}.
- Overflow when the final e≥2047:
  - OF=1, NX=1.
  - Result is ±inf for RNE/RMM, for RUP when sgn=0, and for RDN when sgn=1.
  - Otherwise the result is ±0x7FEFFFFFFFFFFFFF.
- Flags: NX=g|s|OF, UF=tiny&NX, NV=DZ=0.
- spec=1 bypasses arithmetic: o=spec_val, flags={spec_flags,3'b000}, with the same latency.

## Timing
- Latency: in_valid high at edge N, o/flags/o_valid update at edge N+3.
- Throughput: in_valid may be high on consecutive cycles. Results emerge in order, one per cycle.
- o_valid is high for exactly one cycle per accepted input. o and flags are stable between results.
- busy = v1|v2|v3.
- rst asserted at any time immediately clears v1..v3, o, flags, o_valid and busy. In-flight operations are discarded, with no output. After rst deasserts, the first in_valid is accepted on that edge.
- in_valid coincident with a stage-3 output is legal; both proceed.

## Test plan
- 1.0/1.0: q=1<<56, r=0, exp=1023, RNE -> o=0x3FF0000000000000, flags=0, o_valid exactly 3 edges after in_valid.
- 1.0/1.5: q=0xAAAAAAAAAAAAAA, r=2, exp=1023 -> RNE o=0x3FE5555555555555, NX=1. Same input with RUP -> 0x3FE5555555555556.
- Overflow: q=1<<56, r=0, exp=2047 -> RNE o=0x7FF0000000000000, flags OF|NX. Same input with RTZ -> 0x7FEFFFFFFFFFFFFF.
- Subnormal: q=1<<56, r=0, exp=0 -> o=0x0008000000000000, UF=0 (exact). Same with r=1 and RUP -> 0x0008000000000001, UF|NX.
- Throughput: 4 back-to-back in_valid pulses (including one spec=1 with spec_val=0x7FF8000000000000, spec_flags=2'b10) -> 4 consecutive o_valid pulses, in order; the bypass yields NV only.
- Reset mid-flight: two inputs issued, rst pulsed 1 cycle later -> no o_valid, o=0, busy=0; a new input after reset completes normally in 3 cycles.
